// File: rtl/conv_result_buffer_pkg.sv
// Shared constants and the hex-to-7-segment table for the convolution result buffer.
package conv_pkg;

    localparam logic [1:0] C11 = 2'd0;
    localparam logic [1:0] C12 = 2'd1;
    localparam logic [1:0] C21 = 2'd2;
    localparam logic [1:0] C22 = 2'd3;

    localparam logic [6:0] SEG_BLANK = 7'b1111111;
    localparam logic [6:0] SEG_ZERO  = 7'b1000000;

    // Active-low segments ordered {g,f,e,d,c,b,a}.
    function automatic logic [6:0] hex2seg(input logic [3:0] nibble);
        logic [6:0] seg;
        case (nibble)
            4'h0:    seg = 7'b1000000;
            4'h1:    seg = 7'b1111001;
            4'h2:    seg = 7'b0100100;
            4'h3:    seg = 7'b0110000;
            4'h4:    seg = 7'b0011001;
            4'h5:    seg = 7'b0010010;
            4'h6:    seg = 7'b0000010;
            4'h7:    seg = 7'b1111000;
            4'h8:    seg = 7'b0000000;
            4'h9:    seg = 7'b0010000;
            4'hA:    seg = 7'b0001000;
            4'hB:    seg = 7'b0000011;
            4'hC:    seg = 7'b1000110;
            4'hD:    seg = 7'b0100001;
            4'hE:    seg = 7'b0000110;
            default: seg = 7'b0001110;
        endcase
        return seg;
    endfunction

endpackage

// File: rtl/conv_result_buffer_if.sv
// Write/read/display bundle of the result buffer; master drives strobes, slave is the buffer.
interface conv_result_buffer_if #(
    parameter int unsigned DATA_W = 16
) ();

    logic              clr;
    logic [DATA_W-1:0] acc_in;
    logic              we_c11;
    logic              we_c12;
    logic              we_c21;
    logic              we_c22;
    logic [1:0]        read_addr;
    logic [DATA_W-1:0] read_data;
    logic [3:0]        entry_valid;
    logic              all_valid;
    logic              wr_conflict;
    logic [6:0]        seg;
    logic [3:0]        an;
    logic              dp;

    modport master (
        output clr, acc_in, we_c11, we_c12, we_c21, we_c22, read_addr,
        input  read_data, entry_valid, all_valid, wr_conflict, seg, an, dp
    );

    modport slave (
        input  clr, acc_in, we_c11, we_c12, we_c21, we_c22, read_addr,
        output read_data, entry_valid, all_valid, wr_conflict, seg, an, dp
    );

endinterface

// File: rtl/conv_result_buffer_seg7_hex_decode.sv
// Combinational nibble to active-low 7-segment decoder.
module seg7_hex_decode
    import conv_pkg::*;
(
    input  logic [3:0] i_nibble,
    output logic [6:0] o_seg
);

    assign o_seg = hex2seg(i_nibble);

endmodule

// File: rtl/conv_result_buffer.sv
// Four-entry MAC result store with registered read and a multiplexed 4-digit hex display.
// Build option: BLANK_INVALID_EN blanks the display while the selected entry is unwritten.
module conv_result_buffer
    import conv_pkg::*;
#(
    parameter int unsigned DATA_W    = 16,
    parameter int unsigned SCAN_BITS = 16
) (
    input logic                 clk,
    input logic                 rst,
    conv_result_buffer_if.slave bus
);

    logic [DATA_W-1:0]    r_entry [4];
    logic [3:0]           r_valid;
    logic                 r_conflict;
    logic [DATA_W-1:0]    r_read_data;
    logic [15:0]          r_disp_word;
    logic [SCAN_BITS-1:0] r_scan_cnt;
    logic [6:0]           r_seg;
    logic [3:0]           r_an;
    logic                 r_dp;

    logic [3:0]  w_we;
    logic        w_multi;
    logic [15:0] w_rd_ext;
    logic [1:0]  w_digit;
    logic [3:0]  w_nibble;
    logic [6:0]  w_seg_hex;
    logic        w_blank;

    assign w_we[C11] = bus.we_c11;
    assign w_we[C12] = bus.we_c12;
    assign w_we[C21] = bus.we_c21;
    assign w_we[C22] = bus.we_c22;
    // Clearing the lowest set bit leaves something only when two or more strobes are high.
    assign w_multi   = (w_we & (w_we - 4'd1)) != 4'd0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 4; i++) r_entry[i] <= '0;
            r_valid    <= '0;
            r_conflict <= 1'b0;
        end else if (bus.clr) begin
            for (int i = 0; i < 4; i++) r_entry[i] <= '0;
            r_valid    <= '0;
            r_conflict <= 1'b0;
        end else if (w_multi) begin
            r_conflict <= 1'b1;
        end else begin
            for (int i = 0; i < 4; i++) begin
                if (w_we[i]) begin
                    r_entry[i] <= bus.acc_in;
                    r_valid[i] <= 1'b1;
                end
            end
        end
    end

    assign w_rd_ext = 16'(r_read_data);
    assign w_digit  = r_scan_cnt[SCAN_BITS-1 -: 2];
    assign w_nibble = r_disp_word[{w_digit, 2'b00} +: 4];

    seg7_hex_decode u_seg7_hex_decode (
        .i_nibble (w_nibble),
        .o_seg    (w_seg_hex)
    );

`ifdef BLANK_INVALID_EN
    logic r_rd_valid;
    logic r_disp_valid;

    // Valid bit travels with the data so blanking lines up with the shown word.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rd_valid   <= 1'b0;
            r_disp_valid <= 1'b0;
        end else begin
            r_rd_valid   <= r_valid[bus.read_addr];
            r_disp_valid <= r_rd_valid;
        end
    end

    assign w_blank = ~r_disp_valid;
`else
    assign w_blank = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_read_data <= '0;
            r_disp_word <= '0;
            r_scan_cnt  <= '0;
            r_seg       <= SEG_ZERO;
            r_an        <= 4'b1110;
            r_dp        <= 1'b1;
        end else begin
            r_read_data <= r_entry[bus.read_addr];
            r_disp_word <= w_rd_ext;
            r_scan_cnt  <= r_scan_cnt + {{(SCAN_BITS-1){1'b0}}, 1'b1};
            r_seg       <= w_blank ? SEG_BLANK : w_seg_hex;
            r_an        <= ~(4'b0001 << w_digit);
            r_dp        <= (w_digit != bus.read_addr);
        end
    end

    assign bus.read_data   = r_read_data;
    assign bus.entry_valid = r_valid;
    assign bus.all_valid   = &r_valid;
    assign bus.wr_conflict = r_conflict;
    assign bus.seg         = r_seg;
    assign bus.an          = r_an;
    assign bus.dp          = r_dp;

endmodule

// File: tb/tb_conv_result_buffer.sv
// Scoreboard bench: a cycle-indexed reference model queues expected outputs, a monitor compares.
module tb_conv_result_buffer;

    localparam int unsigned DW = 16;
    localparam int unsigned SB = 6;
    localparam int          P  = 64;
    localparam int          SLOT = P / 4;

    localparam logic [6:0] HEX_TAB [16] = '{
        7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
        7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
        7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
        7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
    };

    logic clk = 1'b0;
    logic rst = 1'b1;

    conv_result_buffer_if #(.DATA_W(DW)) bus_if ();

    conv_result_buffer #(
        .DATA_W    (DW),
        .SCAN_BITS (SB)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus_if)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] rd;
        logic [3:0]  ev;
        logic        av;
        logic        cf;
        logic [6:0]  seg;
        logic [3:0]  an;
        logic        dp;
    } exp_t;

    exp_t q[$];
    int   n_cmp = 0;
    int   n_err = 0;

    // Reference state: entries, valid bits, conflict flag, edge count since reset, read history.
    logic [15:0] m_ent [4];
    logic [3:0]  m_val;
    logic        m_cf;
    int          k;
    logic [15:0] rd_h[$];
    logic        rdv_h[$];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] want);
        n_cmp++;
        if (act !== want) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h at %0t", nm, act, want, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 4; i++) m_ent[i] = 16'h0;
        m_val = 4'h0;
        m_cf  = 1'b0;
        k     = 0;
        rd_h  = {16'h0};
        rdv_h = {1'b0};
    endtask

    task automatic step(input logic r, input logic c, input logic [15:0] acc,
                        input logic [3:0] we, input logic [1:0] addr);
        exp_t        e;
        int          d;
        int          nwe;
        logic [15:0] dw;
        logic [15:0] sh;
        logic        dv;
        @(negedge clk);
        #1;
        rst              = r;
        bus_if.clr       = c;
        bus_if.acc_in    = acc;
        bus_if.we_c11    = we[0];
        bus_if.we_c12    = we[1];
        bus_if.we_c21    = we[2];
        bus_if.we_c22    = we[3];
        bus_if.read_addr = addr;
        if (r) begin
            model_reset();
            e.rd  = 16'h0;
            e.ev  = 4'h0;
            e.av  = 1'b0;
            e.cf  = 1'b0;
            e.seg = 7'b1000000;
            e.an  = 4'b1110;
            e.dp  = 1'b1;
        end else begin
            k++;
            // Edge k shows the word read two edges earlier, on the digit chosen at edge k-1.
            d  = ((k - 1) % P) / SLOT;
            dw = (k >= 2) ? rd_h[k-2] : 16'h0;
            dv = (k >= 2) ? rdv_h[k-2] : 1'b0;
            sh = dw >> (4 * d);
            e.seg = HEX_TAB[sh[3:0]];
`ifdef BLANK_INVALID_EN
            if (!dv) e.seg = 7'b1111111;
`else
            if (dv === 1'bx) e.seg = 7'bx;
`endif
            e.an = ~(4'b0001 << d);
            e.dp = (d != int'(addr));
            e.rd = m_ent[addr];
            rd_h.push_back(m_ent[addr]);
            rdv_h.push_back(m_val[addr]);
            nwe = 0;
            for (int i = 0; i < 4; i++) nwe += int'(we[i]);
            if (c) begin
                for (int i = 0; i < 4; i++) m_ent[i] = 16'h0;
                m_val = 4'h0;
                m_cf  = 1'b0;
            end else if (nwe > 1) begin
                m_cf = 1'b1;
            end else begin
                for (int i = 0; i < 4; i++) begin
                    if (we[i]) begin
                        m_ent[i] = acc;
                        m_val[i] = 1'b1;
                    end
                end
            end
            e.ev = m_val;
            e.av = &m_val;
            e.cf = m_cf;
        end
        q.push_back(e);
    endtask

    task automatic idle(input int n, input logic [1:0] addr);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 16'h0, 4'h0, addr);
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (q.size() > 0) begin
                e = q.pop_front();
                chk("read_data",   32'(bus_if.read_data),   32'(e.rd));
                chk("entry_valid", 32'(bus_if.entry_valid), 32'(e.ev));
                chk("all_valid",   32'(bus_if.all_valid),   32'(e.av));
                chk("wr_conflict", 32'(bus_if.wr_conflict), 32'(e.cf));
                chk("seg",         32'(bus_if.seg),         32'(e.seg));
                chk("an",          32'(bus_if.an),          32'(e.an));
                chk("dp",          32'(bus_if.dp),          32'(e.dp));
            end
        end
    end

    initial begin : driver
        logic        r;
        logic        c;
        logic [3:0]  we;
        int          sel;
        bus_if.clr       = 1'b0;
        bus_if.acc_in    = '0;
        bus_if.we_c11    = 1'b0;
        bus_if.we_c12    = 1'b0;
        bus_if.we_c21    = 1'b0;
        bus_if.we_c22    = 1'b0;
        bus_if.read_addr = 2'b00;
        model_reset();

        step(1'b1, 1'b0, 16'h0, 4'h0, 2'b00);
        step(1'b1, 1'b0, 16'h0, 4'h0, 2'b00);

        // Single write to C12 and a full scan of its digits.
        step(1'b0, 1'b0, 16'h1A2B, 4'b0010, 2'b01);
        idle(P + 8, 2'b01);

        // Conflicting strobes, sticky flag, then clear.
        step(1'b0, 1'b0, 16'hFFFF, 4'b1001, 2'b00);
        idle(3, 2'b11);
        step(1'b0, 1'b1, 16'h0, 4'h0, 2'b00);
        idle(2, 2'b01);

        // Fill all four entries and sweep the read address.
        step(1'b0, 1'b0, 16'h0005, 4'b0001, 2'b00);
        step(1'b0, 1'b0, 16'hFFF6, 4'b0010, 2'b00);
        step(1'b0, 1'b0, 16'h0100, 4'b0100, 2'b00);
        step(1'b0, 1'b0, 16'h7FFF, 4'b1000, 2'b00);
        for (int a = 0; a < 4; a++) step(1'b0, 1'b0, 16'h0, 4'h0, 2'(a));

        // Same-cycle write and read of C21 shows the old value first.
        step(1'b0, 1'b0, 16'h1234, 4'b0100, 2'b10);
        idle(2, 2'b10);

        // Clear racing a write: clear wins.
        step(1'b0, 1'b1, 16'hABCD, 4'b0001, 2'b00);
        idle(2, 2'b00);

        // Reset during a write drops it; then C22 starts unwritten and gets 0003.
        step(1'b1, 1'b0, 16'hBEEF, 4'b0001, 2'b00);
        idle(20, 2'b11);
        step(1'b0, 1'b0, 16'h0003, 4'b1000, 2'b11);
        idle(P + 4, 2'b11);

        for (int i = 0; i < 1500; i++) begin
            r   = ($urandom_range(0, 399) == 0);
            c   = ($urandom_range(0, 59) == 0);
            sel = $urandom_range(0, 9);
            if (sel < 4)      we = 4'h0;
            else if (sel < 9) we = 4'b0001 << $urandom_range(0, 3);
            else              we = 4'($urandom_range(0, 15));
            step(r, c, 16'($urandom), we, 2'($urandom_range(0, 3)));
        end
        idle(2, 2'b00);

        repeat (2) @(negedge clk);
        #1;
        chk("queue_drained", 32'(q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
